// File: rtl/vga_timing_pkg.sv
// Shared raster constants and small decode helpers for the VGA timing block.
package vga_timing_pkg;

  localparam int CNT_W       = 11;

  // 640x480@60 segment defaults (pixels / lines)
  localparam int HLINES      = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int VLINES      = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam bit SYNC_POL_DEF = 1'b0;

  // Inclusive window test on an 11-bit count
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  // Map "sync active" onto the pin level for the chosen polarity
  function automatic logic sync_level(input logic active, input bit pol);
    return pol ? active : ~active;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable. Exposes the next-state count so the parent
// can register decode flags in lockstep with the count itself.
module mod_counter #(
  parameter int WIDTH   = 11,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Next count and wrap strobe; wrap only fires on an enabled terminal count
  always_comb begin
    wrap      = en && (count == LAST);
    count_nxt = count;
    if (en) count_nxt = wrap ? '0 : count + WIDTH'(1);
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered
// blank/sync decode and a frame counter. Flags decode the next-state counts
// so they change on the same edge as the counts they describe.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = HLINES,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = VLINES,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblank,
  output logic        vblank,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [1:0]       DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0]       div_q, div_nxt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;

  // Divider next state; CLK_DIV is 1..4 so two bits suffice
  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
  end

  // pix_en is registered so it reads 0 out of reset even when CLK_DIV=1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 2'd0;
      pix_en <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      pix_en <= (div_nxt == DIV_LAST);
    end
  end

  mod_counter #(.WIDTH(CNT_W), .MODULUS(H_TOTAL)) u_hcnt (
    .clk       (clk),
    .rst       (rst),
    .en        (pix_en),
    .count     (hcount),
    .count_nxt (h_nxt),
    .wrap      (h_wrap)
  );

  mod_counter #(.WIDTH(CNT_W), .MODULUS(V_TOTAL)) u_vcnt (
    .clk       (clk),
    .rst       (rst),
    .en        (h_wrap & pix_en),
    .count     (vcount),
    .count_nxt (v_nxt),
    .wrap      (v_wrap)
  );

  // Blank/sync flags decoded from next-state counts, landing with the counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hblank <= 1'b0;
      vblank <= 1'b0;
      blank  <= 1'b0;
      hsync  <= sync_level(1'b0, SYNC_POL);
      vsync  <= sync_level(1'b0, SYNC_POL);
    end else begin
      hblank <= (h_nxt >= H_VIS);
      vblank <= (v_nxt >= V_VIS);
      blank  <= (h_nxt >= H_VIS) || (v_nxt >= V_VIS);
      hsync  <= sync_level(in_window(h_nxt, HS_LO, HS_HI), SYNC_POL);
      vsync  <= sync_level(in_window(v_nxt, VS_LO, VS_HI), SYNC_POL);
    end
  end

  // Frame pulse and count; v_wrap already implies h_wrap and pix_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_start <= v_wrap;
      if (v_wrap) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
